mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 77 +++++++
 rtl/mult_div_unit.sv | 107 ++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and arithmetic helper for the HI/LO multiply-divide unit.
package mult_div_unit_pkg;

    // Operation codes presented on the op port.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Control state encodings.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MULT_RUN = 2'd1;
    localparam logic [1:0] ST_DIV_RUN  = 2'd2;

    // Result waiting for commit; wr=0 means leave HI/LO untouched (divide by zero).
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // Full result of a mult/div operation from the raw rs/rt operands.
    function automatic md_result_t md_compute(input logic [2:0]  op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        md_result_t         res;
        logic signed [63:0] s_prod;
        logic        [63:0] u_prod;
        logic signed [31:0] s_a;
        logic signed [31:0] s_b;
        logic        [31:0] u_b;

        res    = '0;
        s_a    = a;
        // A zero divisor is replaced so the divider never produces X; the
        // result is discarded anyway through res.wr.
        s_b    = (b == 32'd0) ? 32'sd1 : b;
        u_b    = (b == 32'd0) ? 32'd1 : b;
        s_prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        u_prod = {32'd0, a} * {32'd0, b};

        case (op)
            MD_MULT: begin
                res.wr = 1'b1;
                res.hi = s_prod[63:32];
                res.lo = s_prod[31:0];
            end
            MD_MULTU: begin
                res.wr = 1'b1;
                res.hi = u_prod[63:32];
                res.lo = u_prod[31:0];
            end
            MD_DIV: begin
                res.wr = (b != 32'd0);
                // The one overflowing quotient is pinned explicitly instead of
                // relying on how a simulator or synthesis tool wraps it.
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res.lo = 32'h8000_0000;
                    res.hi = 32'd0;
                end else begin
                    res.lo = s_a / s_b;
                    res.hi = s_a % s_b;
                end
            end
            MD_DIVU: begin
                res.wr = (b != 32'd0);
                res.lo = a / u_b;
                res.hi = a % u_b;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the request is accepted and committed after a
// fixed busy period, mimicking the latency of an iterative datapath.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    md_result_t       pend_q,  pend_d;
    md_result_t       result;

    assign busy = (state_q != ST_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Next-state logic: accept requests in IDLE, count down and commit in the run states.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        result  = md_compute(op, A, B);

        case (state_q)
            ST_IDLE: begin
                // A start always takes priority, so a simultaneous write is dropped
                // even when the start itself carries a non-arithmetic op.
                if (start) begin
                    if (op == MD_MULT || op == MD_MULTU) begin
                        pend_d  = result;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                        state_d = ST_MULT_RUN;
                    end else if (op == MD_DIV || op == MD_DIVU) begin
                        pend_d  = result;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        state_d = ST_DIV_RUN;
                    end
                end else if (we) begin
                    if (op == MD_MTHI) begin
                        hi_d = A;
                    end else if (op == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
                // Requests arriving here are ignored; the stall logic keeps them out.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pend_q.wr) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight without committing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic        we;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int assert_count = 0;
    int fail_count   = 0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYC),
        .DIV_CYCLES (DIV_CYC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .we     (we),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Count busy cycles, starting at the first negedge after the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic do_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [31:0] prev_hi;
        prev_hi = HI;
        do_start(o, a, b);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_hi_hold"}, HI, prev_hi);
        wait_done(n);
        check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        we      = 1'b0;
        op      = 3'd7;
        A       = 32'd0;
        B       = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // mthi / mtlo in idle
        we = 1'b1; op = MD_MTHI; A = 32'h1234_5678;
        #1 check("mthi_before_edge", HI, 32'd0);
        @(negedge clk);
        we = 1'b0;
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_lo", LO, 32'd0);
        we = 1'b1; op = MD_MTLO; A = 32'hCAFE_BABE;
        @(negedge clk);
        we = 1'b0;
        check("mtlo_lo", LO, 32'hCAFE_BABE);
        check("mtlo_hi", HI, 32'h1234_5678);

        // arithmetic
        run_op("mult_m2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_m2x3", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_CYC, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult_big", MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, MULT_CYC, 32'hC000_0000, 32'h8000_0000);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYC, 32'hFFFF_FFFE, 32'h0000_0001);

        // div -7/2 with operands scrambled every busy cycle
        do_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            A = $urandom;
            B = $urandom;
            @(negedge clk);
            n++;
        end
        check("div_cycles", 32'(n), 32'(DIV_CYC));
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        run_op("divu_by0", MD_DIVU, 32'd7, 32'd0, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYC, 32'h0000_0000, 32'h8000_0000);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, DIV_CYC, 32'h0000_0001, 32'hFFFF_FFFD);

        // divu 100/7 with a second start and a mthi injected while busy
        do_start(MD_DIVU, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; op = MD_MULT; A = 32'd5; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        we = 1'b1; op = MD_MTHI; A = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0;
        wait_done(n);
        check("busy_req_cycles", 32'(n), 32'(DIV_CYC - 4));
        check("busy_req_lo", LO, 32'd14);
        check("busy_req_hi", HI, 32'd2);
        @(negedge clk);
        check("busy_req_no_restart", 32'(busy), 32'd0);

        // start and we together: start (op=mthi, a no-op) wins, write dropped
        start = 1'b1; we = 1'b1; op = MD_MTHI; A = 32'hAAAA_5555;
        @(negedge clk);
        start = 1'b0; we = 1'b0;
        check("start_we_hi", HI, 32'd2);
        check("start_we_busy", 32'(busy), 32'd0);
        // we with an arithmetic op is a no-op
        we = 1'b1; op = MD_MULT; A = 32'h1111_1111;
        @(negedge clk);
        we = 1'b0;
        check("we_badop_hi", HI, 32'd2);
        check("we_badop_lo", LO, 32'd14);

        // reset during MULT_RUN at busy cycle 2
        do_start(MD_MULT, 32'd3, 32'd3);
        @(negedge clk);
        check("rst_mid_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post_rst_mult", MD_MULT, 32'd6, 32'd7, MULT_CYC, 32'd0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
